// File: rtl/phase_timer.sv
// Phase countdown timer for the traffic-light controller: prescales clk to
// one-second ticks, reports expiry, remaining seconds and a blink cadence.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no phase loaded since reset; all outputs low
// RUN     | counting down; t_busy high, t_remaining valid
// EXPIRED | phase finished (or loaded with 0); t_done and t_flicker high
module phase_timer #(
    parameter int CLK_PER_SEC    = 50_000_000,
    parameter int FLICKER_WINDOW = 5,
    parameter int FLICKER_HALF   = CLK_PER_SEC / 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       t_start,
    input  logic [4:0] t_length,
    output logic       t_done,
    output logic       t_flicker,
    output logic [4:0] t_remaining,
    output logic       t_busy
);

    localparam int CPS_EFF = (CLK_PER_SEC < 1) ? 1 : CLK_PER_SEC;
    localparam int FH_EFF  = (FLICKER_HALF < 1) ? 1 : FLICKER_HALF;
    localparam int PW      = (CPS_EFF > 1) ? $clog2(CPS_EFF) : 1;
    localparam int HW      = (FH_EFF > 1) ? $clog2(FH_EFF) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CPS_EFF - 1);
    localparam logic [HW-1:0] HALF_MAX  = HW'(FH_EFF - 1);
    localparam logic [4:0]    WIN_TOP   = 5'(FLICKER_WINDOW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    rem_q, rem_d;
    logic [HW-1:0] half_q, half_d;
    logic          phase_q, phase_d;

    logic          t_done_q, t_done_d;
    logic          t_flicker_q, t_flicker_d;
    logic [4:0]    t_remaining_q, t_remaining_d;
    logic          t_busy_q, t_busy_d;

    logic          win_q, win_d;

    function automatic logic in_window(input logic [4:0] r);
        return (r != 5'd0) && (r <= WIN_TOP);
    endfunction

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        half_d  = half_q;
        phase_d = phase_q;

        // A load wins over any tick or expiry in the same cycle.
        if (t_start) begin
            rem_d   = t_length;
            presc_d = '0;
            state_d = (t_length == 5'd0) ? EXPIRED : RUN;
        end else if (state_q == RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (rem_q != 5'd0) begin
                    rem_d = rem_q - 5'd1;
                end
                if (rem_q <= 5'd1) begin
                    state_d = EXPIRED;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        if (state_d != RUN) begin
            rem_d = 5'd0;
        end

        win_q = (state_q == RUN) && in_window(rem_q);
        win_d = (state_d == RUN) && in_window(rem_d);

        // Phase restarts high only on entry; later second ticks leave it alone.
        if (!win_d) begin
            phase_d = 1'b0;
            half_d  = '0;
        end else if (t_start || !win_q) begin
            phase_d = 1'b1;
            half_d  = '0;
        end else if (half_q == HALF_MAX) begin
            phase_d = ~phase_q;
            half_d  = '0;
        end else begin
            half_d  = half_q + 1'b1;
        end

        t_busy_d      = (state_d == RUN);
        t_done_d      = (state_d == EXPIRED);
        t_remaining_d = (state_d == RUN) ? rem_d : 5'd0;
        if (state_d == EXPIRED) begin
            t_flicker_d = 1'b1;
        end else begin
            t_flicker_d = win_d & phase_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            rem_q         <= 5'd0;
            half_q        <= '0;
            phase_q       <= 1'b0;
            t_done_q      <= 1'b0;
            t_flicker_q   <= 1'b0;
            t_remaining_q <= 5'd0;
            t_busy_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            rem_q         <= rem_d;
            half_q        <= half_d;
            phase_q       <= phase_d;
            t_done_q      <= t_done_d;
            t_flicker_q   <= t_flicker_d;
            t_remaining_q <= t_remaining_d;
            t_busy_q      <= t_busy_d;
        end
    end

    assign t_done      = t_done_q;
    assign t_flicker   = t_flicker_q;
    assign t_remaining = t_remaining_q;
    assign t_busy      = t_busy_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: a time-since-start model checked every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_phase_timer;

    localparam int CPS = 4;
    localparam int FW  = 2;
    localparam int FH  = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       t_start = 1'b0;
    logic [4:0] t_length = 5'd0;
    logic       t_done, t_flicker, t_busy;
    logic [4:0] t_remaining;

    int n_checks = 0;
    int n_pass   = 0;

    phase_timer #(
        .CLK_PER_SEC   (CPS),
        .FLICKER_WINDOW(FW),
        .FLICKER_HALF  (FH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .t_start    (t_start),
        .t_length   (t_length),
        .t_done     (t_done),
        .t_flicker  (t_flicker),
        .t_remaining(t_remaining),
        .t_busy     (t_busy)
    );

    always #5 clk = ~clk;

    // Model: only "was a phase started, with what length, how many edges ago".
    logic m_active = 1'b0;
    int   m_len    = 0;
    int   m_k      = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (t_start) begin
            m_active <= 1'b1;
            m_len    <= int'(t_length);
            m_k      <= 0;
        end else if (m_active) begin
            m_k <= m_k + 1;
        end
    end

    task automatic model_out(output logic done, output logic flk,
                             output logic busy, output logic [4:0] rem);
        int entry;
        int secs;
        done = 1'b0; flk = 1'b0; busy = 1'b0; rem = 5'd0;
        if (m_active) begin
            if (m_k >= m_len * CPS) begin
                done = 1'b1;
                flk  = 1'b1;
            end else begin
                busy  = 1'b1;
                secs  = m_len - m_k / CPS;
                rem   = 5'(secs);
                entry = (m_len <= FW) ? 0 : (m_len - FW) * CPS;
                if (secs <= FW && m_k >= entry)
                    flk = (((m_k - entry) / FH) % 2) == 0;
            end
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        logic e_done, e_flk, e_busy;
        logic [4:0] e_rem;
        model_out(e_done, e_flk, e_busy, e_rem);
        check("model_done", int'(t_done), int'(e_done));
        check("model_flicker", int'(t_flicker), int'(e_flk));
        check("model_busy", int'(t_busy), int'(e_busy));
        check("model_remaining", int'(t_remaining), int'(e_rem));
    end

    // Leaves us 1 time unit after the n-th following rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns just after the sampling edge (k=0).
    task automatic start(input logic [4:0] len);
        t_start  = 1'b1;
        t_length = len;
        step(1);
        t_start  = 1'b0;
        t_length = 5'd31;
    endtask

    initial begin
        // Scenario 1: idle after reset
        step(2);
        reset = 1'b0;
        step(20);
        check("idle_done", int'(t_done), 0);
        check("idle_busy", int'(t_busy), 0);
        check("idle_flicker", int'(t_flicker), 0);

        // Scenario 2: length 3
        start(5'd3);
        check("l3_rem_k0", int'(t_remaining), 3);
        check("l3_busy_k0", int'(t_busy), 1);
        step(4);
        check("l3_rem_k4", int'(t_remaining), 2);
        step(7);
        check("l3_rem_k11", int'(t_remaining), 1);
        check("l3_done_k11", int'(t_done), 0);
        step(1);
        check("l3_done_k12", int'(t_done), 1);
        check("l3_busy_k12", int'(t_busy), 0);
        check("l3_rem_k12", int'(t_remaining), 0);
        step(5);
        check("l3_done_held", int'(t_done), 1);

        // Scenario 3: length 5 through the flicker window
        start(5'd5);
        check("l5_done_cleared", int'(t_done), 0);
        step(11);
        check("l5_flk_k11", int'(t_flicker), 0);
        step(1);
        check("l5_flk_k12", int'(t_flicker), 1);
        check("l5_rem_k12", int'(t_remaining), 2);
        step(1);
        check("l5_flk_k13", int'(t_flicker), 0);
        step(6);
        check("l5_flk_k19", int'(t_flicker), 0);
        check("l5_rem_k19", int'(t_remaining), 1);
        step(1);
        check("l5_done_k20", int'(t_done), 1);
        check("l5_flk_k20", int'(t_flicker), 1);

        // Scenario 4: restart mid-run straight into the window
        start(5'd10);
        step(5);
        start(5'd2);
        check("rs_flk_k0", int'(t_flicker), 1);
        check("rs_rem_k0", int'(t_remaining), 2);
        step(1);
        check("rs_flk_k1", int'(t_flicker), 0);
        step(6);
        check("rs_done_k7", int'(t_done), 0);
        step(1);
        check("rs_done_k8", int'(t_done), 1);
        step(30);
        check("rs_done_held", int'(t_done), 1);

        // Scenario 5: zero length, then a normal load clears t_done
        start(5'd0);
        check("z_done", int'(t_done), 1);
        check("z_flk", int'(t_flicker), 1);
        check("z_busy", int'(t_busy), 0);
        start(5'd3);
        check("z_done_cleared", int'(t_done), 0);
        check("z_rem", int'(t_remaining), 3);

        // Holding t_start reloads every cycle, so the count does not advance
        t_start  = 1'b1;
        t_length = 5'd3;
        step(9);
        check("hold_rem", int'(t_remaining), 3);
        t_start  = 1'b0;
        step(4);
        check("hold_rem_after", int'(t_remaining), 2);

        // Scenario 6: async reset at remaining=3
        start(5'd5);
        step(9);
        check("rst_rem_before", int'(t_remaining), 3);
        #2 reset = 1'b1;
        #1;
        check("rst_busy_async", int'(t_busy), 0);
        check("rst_rem_async", int'(t_remaining), 0);
        step(2);
        reset = 1'b0;
        step(40);
        check("rst_no_done", int'(t_done), 0);
        check("rst_no_busy", int'(t_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
